// File: rtl/unidad_control_id_pkg.sv
// Shared definitions for the control word: field positions, opcodes,
// decoded control-word constants and the decode-stage FSM encoding.
package unidad_control_id_pkg;

  localparam int unsigned CTRL_W = 10;

  // Bit positions of the control fields inside the 10-bit word
  localparam int unsigned BIT_SALTOINCOND = 9;
  localparam int unsigned BIT_REGDEST     = 8;
  localparam int unsigned BIT_FUENTEALU   = 7;
  localparam int unsigned BIT_MEMAREG     = 6;
  localparam int unsigned BIT_ESCRREG     = 5;
  localparam int unsigned BIT_LEERMEM     = 4;
  localparam int unsigned BIT_ESCRMEM     = 3;
  localparam int unsigned BIT_SALTOCOND   = 2;
  localparam int unsigned BIT_ALUOP_MSB   = 1;
  localparam int unsigned BIT_ALUOP_LSB   = 0;

  // Opcodes recognised by the decoder
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Decoded control words
  localparam logic [CTRL_W-1:0] CW_R    = 10'h122;
  localparam logic [CTRL_W-1:0] CW_LW   = 10'h0F0;
  localparam logic [CTRL_W-1:0] CW_SW   = 10'h088;
  localparam logic [CTRL_W-1:0] CW_BEQ  = 10'h005;
  localparam logic [CTRL_W-1:0] CW_J    = 10'h200;
  localparam logic [CTRL_W-1:0] CW_ADDI = 10'h0A0;
  localparam logic [CTRL_W-1:0] CW_NOP  = 10'h000;

  // Decode-stage FSM states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } estado_e;

endpackage

// File: rtl/unidad_control_id_decodificador_ctrl.sv
// Purely combinational opcode decoder: opcode -> control word plus an
// "unknown opcode" flag. Unknown opcodes produce the all-zero word.
module decodificador_ctrl
  import unidad_control_id_pkg::*;
(
  input  logic [5:0]        opcode_i,
  output logic [CTRL_W-1:0] control_o,
  output logic              invalido_o
);

  // Table lookup of the control word for the current opcode
  always_comb begin
    control_o  = CW_NOP;
    invalido_o = 1'b0;
    case (opcode_i)
      OP_R:    control_o = CW_R;
      OP_LW:   control_o = CW_LW;
      OP_SW:   control_o = CW_SW;
      OP_BEQ:  control_o = CW_BEQ;
      OP_J:    control_o = CW_J;
      OP_ADDI: control_o = CW_ADDI;
      default: begin
        control_o  = CW_NOP;
        invalido_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/unidad_control_id.sv
// Decode stage control unit: registers the decoded control word into
// ID/EX, inserts bubbles on load-use hazards and after branch/jump
// flushes, freezes PC and IF/ID on a stall and counts inserted bubbles.
module unidad_control_id
  import unidad_control_id_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        Opcode,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic              ex_LeerMem,
  input  logic [4:0]        ex_Rt,
  input  logic              flush_req,
  output logic [CTRL_W-1:0] Control,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              invalido,
  output logic [CNT_W-1:0]  cnt_burbujas
);

  // Counter reload value: the request edge itself is the first bubble
  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  estado_e           state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic [CTRL_W-1:0] control_q, control_d;
  logic              invalido_q, invalido_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CTRL_W-1:0] dec_control_s;
  logic              dec_invalido_s;
  logic              haz_s;
  logic              stall_s;
  logic              bubble_s;

  decodificador_ctrl u_dec (
    .opcode_i   (Opcode),
    .control_o  (dec_control_s),
    .invalido_o (dec_invalido_s)
  );

  // Load-use hazard: EX loads into a non-zero register read by ID
  assign haz_s = ex_LeerMem & (ex_Rt != 5'd0) & ((ex_Rt == Rs) | (ex_Rt == Rt));

  // Next-state, next control word and stall decision
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    control_d   = dec_control_s;
    invalido_d  = dec_invalido_s;
    bubble_s    = 1'b0;
    stall_s     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          control_d  = CW_NOP;
          invalido_d = 1'b0;
          bubble_s   = 1'b1;
          if (FLUSH_RELOAD != 3'd0) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end else begin
            state_d     = ST_RUN;
            flush_cnt_d = 3'd0;
          end
        end else if (haz_s) begin
          control_d  = CW_NOP;
          invalido_d = 1'b0;
          bubble_s   = 1'b1;
          stall_s    = 1'b1;
        end else begin
          control_d  = dec_control_s;
          invalido_d = dec_invalido_s;
        end
      end
      ST_FLUSH: begin
        // IF/ID holds discarded instructions: no stall, hazard ignored
        control_d  = CW_NOP;
        invalido_d = 1'b0;
        bubble_s   = 1'b1;
        if (flush_req) begin
          flush_cnt_d = FLUSH_RELOAD;
        end else if (flush_cnt_q <= 3'd1) begin
          flush_cnt_d = 3'd0;
          state_d     = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
        control_d   = CW_NOP;
        invalido_d  = 1'b0;
      end
    endcase
  end

  // Saturating bubble counter next value
  always_comb begin
    if (bubble_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, control word and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      control_q   <= CW_NOP;
      invalido_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      control_q   <= control_d;
      invalido_q  <= invalido_d;
      cnt_q       <= cnt_d;
    end
  end

  // Freeze is never asserted while reset is held
  assign PCWrite      = ~(stall_s & rst_n);
  assign IFIDWrite    = ~(stall_s & rst_n);
  assign Control      = control_q;
  assign invalido     = invalido_q;
  assign cnt_burbujas = cnt_q;

endmodule

// File: tb/tb_unidad_control_id.sv
// Directed testbench for unidad_control_id (small counter width so that
// saturation is reachable in a short run).
module tb_unidad_control_id;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [5:0]       Opcode;
  logic [4:0]       Rs;
  logic [4:0]       Rt;
  logic             ex_LeerMem;
  logic [4:0]       ex_Rt;
  logic             flush_req;
  logic [9:0]       Control;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             invalido;
  logic [CNT_W-1:0] cnt_burbujas;

  int checks = 0;
  int errors = 0;

  unidad_control_id #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Opcode       (Opcode),
    .Rs           (Rs),
    .Rt           (Rt),
    .ex_LeerMem   (ex_LeerMem),
    .ex_Rt        (ex_Rt),
    .flush_req    (flush_req),
    .Control      (Control),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .invalido     (invalido),
    .cnt_burbujas (cnt_burbujas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_haz();
    ex_LeerMem = 1'b0; ex_Rt = 5'd0; Rs = 5'd1; Rt = 5'd2; flush_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Opcode = 6'b100011; flush_req = 1'b0;
    ex_LeerMem = 1'b1; ex_Rt = 5'd5; Rs = 5'd5; Rt = 5'd0;
    #12;
    checks++; if (Control !== 10'h000) begin errors++; $display("FAIL reset_control got %h exp 000", Control); end
    checks++; if (invalido !== 1'b0) begin errors++; $display("FAIL reset_invalido got %b exp 0", invalido); end
    checks++; if (cnt_burbujas !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_burbujas); end
    checks++; if (PCWrite !== 1'b1 || IFIDWrite !== 1'b1) begin errors++; $display("FAIL reset_write got %b%b exp 11", PCWrite, IFIDWrite); end
    no_haz();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    logic [5:0] ops [6];
    logic [9:0] cws [6];
    ops[0] = 6'b100011; cws[0] = 10'h0F0;
    ops[1] = 6'b000000; cws[1] = 10'h122;
    ops[2] = 6'b101011; cws[2] = 10'h088;
    ops[3] = 6'b000100; cws[3] = 10'h005;
    ops[4] = 6'b000010; cws[4] = 10'h200;
    ops[5] = 6'b001000; cws[5] = 10'h0A0;
    for (int i = 0; i < 6; i++) begin
      no_haz(); Opcode = ops[i];
      tick();
      checks++; if (Control !== cws[i] || invalido !== 1'b0) begin errors++; $display("FAIL decode_%0d got %h/%b exp %h/0", i, Control, invalido, cws[i]); end
    end
    checks++; if (PCWrite !== 1'b1 || cnt_burbujas !== 4'd0) begin errors++; $display("FAIL decode_side got pc=%b cnt=%0d exp 1/0", PCWrite, cnt_burbujas); end
  endtask

  task automatic test_load_use();
    Opcode = 6'b000000; ex_LeerMem = 1'b1; ex_Rt = 5'd5; Rs = 5'd5; Rt = 5'd0;
    #1;
    checks++; if (PCWrite !== 1'b0 || IFIDWrite !== 1'b0) begin errors++; $display("FAIL lu_stall got %b%b exp 00", PCWrite, IFIDWrite); end
    tick();
    checks++; if (Control !== 10'h000 || cnt_burbujas !== 4'd1) begin errors++; $display("FAIL lu_bubble got %h cnt=%0d exp 000/1", Control, cnt_burbujas); end
    ex_LeerMem = 1'b0;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL lu_release got %b exp 1", PCWrite); end
    tick();
    checks++; if (Control !== 10'h122 || cnt_burbujas !== 4'd1) begin errors++; $display("FAIL lu_resume got %h cnt=%0d exp 122/1", Control, cnt_burbujas); end
    ex_LeerMem = 1'b1; ex_Rt = 5'd7; Rs = 5'd1; Rt = 5'd7;
    #1;
    checks++; if (IFIDWrite !== 1'b0) begin errors++; $display("FAIL lu_rt_stall got %b exp 0", IFIDWrite); end
    tick();
    checks++; if (Control !== 10'h000 || cnt_burbujas !== 4'd2) begin errors++; $display("FAIL lu_rt_bubble got %h cnt=%0d exp 000/2", Control, cnt_burbujas); end
  endtask

  task automatic test_reg0();
    Opcode = 6'b100011; ex_LeerMem = 1'b1; ex_Rt = 5'd0; Rs = 5'd0; Rt = 5'd0; flush_req = 1'b0;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL reg0_nostall got %b exp 1", PCWrite); end
    tick();
    checks++; if (Control !== 10'h0F0 || cnt_burbujas !== 4'd2) begin errors++; $display("FAIL reg0_decode got %h cnt=%0d exp 0F0/2", Control, cnt_burbujas); end
  endtask

  task automatic test_flush();
    no_haz(); Opcode = 6'b001000; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    checks++; if (Control !== 10'h000) begin errors++; $display("FAIL flush_b1 got %h exp 000", Control); end
    tick();
    checks++; if (Control !== 10'h000) begin errors++; $display("FAIL flush_b2 got %h exp 000", Control); end
    tick();
    checks++; if (Control !== 10'h0A0 || cnt_burbujas !== 4'd4) begin errors++; $display("FAIL flush_resume got %h cnt=%0d exp 0A0/4", Control, cnt_burbujas); end
  endtask

  task automatic test_flush_haz();
    Opcode = 6'b001000; ex_LeerMem = 1'b1; ex_Rt = 5'd3; Rs = 5'd3; Rt = 5'd0; flush_req = 1'b1;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL fh_pcwrite got %b exp 1", PCWrite); end
    tick();
    flush_req = 1'b0;
    #1;
    checks++; if (PCWrite !== 1'b1 || IFIDWrite !== 1'b1) begin errors++; $display("FAIL fh_inflush got %b%b exp 11", PCWrite, IFIDWrite); end
    tick();
    ex_LeerMem = 1'b0;
    checks++; if (Control !== 10'h000) begin errors++; $display("FAIL fh_b2 got %h exp 000", Control); end
    tick();
    checks++; if (Control !== 10'h0A0 || cnt_burbujas !== 4'd6) begin errors++; $display("FAIL fh_total got %h cnt=%0d exp 0A0/6", Control, cnt_burbujas); end
  endtask

  task automatic test_flush_reload();
    no_haz(); Opcode = 6'b001000; flush_req = 1'b1;
    tick();
    tick();
    flush_req = 1'b0;
    tick();
    checks++; if (Control !== 10'h000) begin errors++; $display("FAIL reload_b3 got %h exp 000", Control); end
    tick();
    checks++; if (Control !== 10'h0A0 || cnt_burbujas !== 4'd9) begin errors++; $display("FAIL reload_resume got %h cnt=%0d exp 0A0/9", Control, cnt_burbujas); end
  endtask

  task automatic test_invalid();
    no_haz(); Opcode = 6'b111111;
    tick();
    checks++; if (Control !== 10'h000 || invalido !== 1'b1 || cnt_burbujas !== 4'd9) begin errors++; $display("FAIL invalid got %h inv=%b cnt=%0d exp 000/1/9", Control, invalido, cnt_burbujas); end
    Opcode = 6'b101011;
    tick();
    checks++; if (Control !== 10'h088 || invalido !== 1'b0) begin errors++; $display("FAIL invalid_clear got %h inv=%b exp 088/0", Control, invalido); end
  endtask

  task automatic test_reset_mid_flush();
    no_haz(); Opcode = 6'b100011; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (Control !== 10'h000 || cnt_burbujas !== 4'd0 || invalido !== 1'b0) begin errors++; $display("FAIL rmf_reset got %h cnt=%0d inv=%b exp 000/0/0", Control, cnt_burbujas, invalido); end
    #2 rst_n = 1'b1;
    tick();
    checks++; if (Control !== 10'h0F0 || cnt_burbujas !== 4'd0) begin errors++; $display("FAIL rmf_decode got %h cnt=%0d exp 0F0/0", Control, cnt_burbujas); end
  endtask

  task automatic test_saturation();
    Opcode = 6'b000000; ex_LeerMem = 1'b1; ex_Rt = 5'd9; Rs = 5'd9; Rt = 5'd0; flush_req = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    checks++; if (cnt_burbujas !== 4'd14) begin errors++; $display("FAIL sat_count got %0d exp 14", cnt_burbujas); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (cnt_burbujas !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", cnt_burbujas); end
    ex_LeerMem = 1'b0;
    tick();
    checks++; if (Control !== 10'h122 || cnt_burbujas !== 4'd15) begin errors++; $display("FAIL sat_resume got %h cnt=%0d exp 122/15", Control, cnt_burbujas); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_reg0();
    test_flush();
    test_flush_haz();
    test_flush_reload();
    test_invalid();
    test_reset_mid_flush();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
